mul_sgn_share_arb: RTL
======================

Name: mul_sgn_share_arb

Overview:
- Round-robin arbiter and pipeline sequencer that shares one signed (Baugh-Wooley, CSA + prefix adder) multiplier datapath among NumReq requesters.
- Each requester offers an operand pair over a valid/ready handshake. The block muxes the granted pair into the combinational multiplier and registers the product through a Latency-deep tagged pipeline.
- Each product is returned on a shared result bus to the requester that issued it, with per-requester valid/ready backpressure.
- Sits between DSP/accelerator clients and the multiplier core.

Parameters:
- NumReq, 4: number of requesters; must be ≥ 2.
- widthX, 8: X operand width; must be ≤ widthY.
- widthY, 8: Y operand width.
- speed, 2: passed unchanged to the multiplier (0 ripple, 1 Brent-Kung, 2 Sklansky).
- Latency, 2: number of pipeline register stages after the multiplier; must be ≥ 1.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NumReq  requester i offers an operand pair.
- req_ready_o  out  NumReq  one-hot or zero; operand pair of requester i accepted this cycle.
- req_x_i  in  NumReq*widthX  packed X operands; requester i occupies bits [i*widthX +: widthX]; two's complement.
- req_y_i  in  NumReq*widthY  packed Y operands, same packing scheme; two's complement.
- rsp_valid_o  out  NumReq  one-hot or zero; result for requester i is on rsp_p_o.
- rsp_ready_i  in  NumReq  requester i accepts its result.
- rsp_p_o  out  widthX+widthY  signed product X*Y; full width, no truncation.
- busy_o  out  1  at least one pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync release):
  - All stage valids = 0; round-robin pointer = 0.
  - rsp_valid_o = 0, req_ready_o = 0, busy_o = 0.
  - Stage data and tags are don't-care; rsp_p_o is don't-care while rsp_valid_o = 0.
- Pipeline:
  - Stages s = 1..Latency, each holding {valid, id[$clog2(NumReq)-1:0], product}.
  - The output is stage Latency: rsp_valid_o = onehot(id) & valid; rsp_p_o = product.
- Advance:
  - adv = ~valid[Latency] | rsp_ready_i[id[Latency]].
  - When adv = 1, every stage shifts by one. Stage 1 loads {issue, grant_id, mult(X_g, Y_g)}.
  - When adv = 0, all stages hold (global stall; no bubble collapsing).
- Arbitration (combinational):
  - Grant goes to the lowest index j ≥ ptr with req_valid_i[j] = 1. If none, it wraps to the lowest index < ptr.
  - issue = any(req_valid_i) & adv.
  - req_ready_o[grant_id] = issue; all other bits of req_ready_o are 0.
- Pointer update:
  - On issue, ptr ← (grant_id + 1) mod NumReq, wrapping from NumReq-1 to 0.
  - With no issue, ptr holds.
- Latency: a pair accepted in cycle t appears on rsp_valid_o in cycle t+Latency when no stall occurs.
- Throughput: one result per cycle with rsp_ready_i held high.
- Simultaneous events:
  - Output accepted and a new issue in the same cycle are both allowed (full-rate streaming).
  - A requester may be granted again before its earlier result drains. Results for the same requester return in issue order.
- Stability: req_valid_i may drop without ready (no stickiness is required of requesters). rsp_valid_o/rsp_p_o stay stable while stalled.
- Arithmetic: product = sign-extended X × sign-extended Y, widthX+widthY bits.
  - Example: −2^(widthX−1) × −2^(widthY−1) = +2^(widthX+widthY−2) is representable and must be exact.
- busy_o = OR of stage valids.
- Reset mid-operation: in-flight results are discarded with no response. Outputs reach the reset values asynchronously.

Test Plan:
- Single request, Latency=2: req 1 sends X=8'hFD (−3), Y=8'h05, rsp_ready_i all 1. Required: req_ready_o=4'b0010 in cycle t; rsp_valid_o=4'b0010 and rsp_p_o=16'hFFF1 in cycle t+2; busy_o high for cycles t+1 and t+2.
- Extremes: X=8'h80, Y=8'h80 → 16'h4000. X=8'h7F, Y=8'h80 → 16'hC080. X=8'hFF, Y=8'hFF → 16'h0001.
- Round-robin: all four req_valid_i held high for 8 cycles starting from ptr=0. Required grant sequence 0,1,2,3,0,1,2,3; results return in the same order with the correct tags.
- Backpressure: stream from requester 2 with rsp_ready_i[2]=0 for 3 cycles. Required: rsp_valid_o/rsp_p_o held stable; req_ready_o=0 throughout the stall; no loss or duplication after release; 4 issued pairs yield exactly 4 responses.
- Wrap and skip: ptr=3 with only reqs 0 and 2 valid. Required: grant 0, then ptr=1, then grant 2.
- Reset mid-flight: assert rst_ni=0 with 2 entries in flight. Required: rsp_valid_o=0 and busy_o=0 immediately, without waiting for a clock edge; first grant after release goes to requester 0.

Source files
------------

// File: rtl/mul_sgn_share_arb.sv
// Round-robin shared signed multiplier: arbitrates NumReq operand streams into one
// Baugh-Wooley multiplier and returns tagged products through a Latency-deep pipeline.
module mul_sgn_share_arb #(
    parameter int NumReq  = 4,
    parameter int widthX  = 8,
    parameter int widthY  = 8,
    parameter int speed   = 2,
    parameter int Latency = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq*widthX-1:0]     req_x_i,
    input  logic [NumReq*widthY-1:0]     req_y_i,
    output logic [NumReq-1:0]            rsp_valid_o,
    input  logic [NumReq-1:0]            rsp_ready_i,
    output logic [widthX+widthY-1:0]     rsp_p_o,
    output logic                         busy_o
);

    localparam int PW  = widthX + widthY;
    localparam int IdW = $clog2(NumReq);

    // Baugh-Wooley correction: 2^(m-1) + 2^(n-1) - 2^(m+n-1), taken modulo 2^(m+n).
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << (widthX - 1)) +
                                         (PW'(1) << (widthY - 1)) +
                                         (PW'(1) << (PW - 1));

    function automatic logic [PW-1:0] f_prefix_add(input logic [PW-1:0] a,
                                                   input logic [PW-1:0] b);
        logic [PW-1:0] p;
        logic [PW-1:0] gg;
        logic [PW-1:0] pp;
        p  = a ^ b;
        gg = a & b;
        pp = p;
        if (speed == 0) begin
            for (int i = 1; i < PW; i++) begin
                gg[i] = gg[i] | (pp[i] & gg[i-1]);
            end
        end else if (speed == 1) begin
            // Brent-Kung: up-sweep builds power-of-two spans, down-sweep fills the gaps.
            for (int l = 0; (1 << l) < PW; l++) begin
                for (int i = 0; i < PW; i++) begin
                    if ((i % (2 << l)) == ((2 << l) - 1)) begin
                        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                        pp[i] = pp[i] & pp[i - (1 << l)];
                    end
                end
            end
            for (int l = $clog2(PW) - 1; l >= 0; l--) begin
                for (int i = 0; i < PW; i++) begin
                    if ((i >= (2 << l)) && ((i % (2 << l)) == ((1 << l) - 1))) begin
                        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                        pp[i] = pp[i] & pp[i - (1 << l)];
                    end
                end
            end
        end else begin
            for (int l = 0; (1 << l) < PW; l++) begin
                for (int i = 0; i < PW; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
                        pp[i] = pp[i] & pp[((i >> l) << l) - 1];
                    end
                end
            end
        end
        return p ^ {gg[PW-2:0], 1'b0};
    endfunction

    function automatic logic [PW-1:0] f_bw_mult(input logic [widthX-1:0] x,
                                                input logic [widthY-1:0] y);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [PW-1:0] row;
        logic [PW-1:0] t;
        s = BW_CONST;
        c = '0;
        for (int j = 0; j < widthY; j++) begin
            row = '0;
            for (int i = 0; i < widthX; i++) begin
                // Mixed sign-bit/magnitude-bit terms carry negative weight, so they are inverted.
                if ((i == widthX - 1) != (j == widthY - 1)) begin
                    row[i+j] = ~(x[i] & y[j]);
                end else begin
                    row[i+j] = x[i] & y[j];
                end
            end
            t = s ^ c ^ row;
            c = ((s & c) | (s & row) | (c & row)) << 1;
            s = t;
        end
        return f_prefix_add(s, c);
    endfunction

    logic [IdW-1:0]    r_ptr;
    logic [Latency:1]  r_vld;
    logic [IdW-1:0]    r_id   [1:Latency];
    logic [PW-1:0]     r_prod [1:Latency];

    logic              w_any;
    logic [IdW-1:0]    w_grant_id;
    logic              w_adv;
    logic              w_issue;
    logic [widthX-1:0] w_x;
    logic [widthY-1:0] w_y;
    logic [PW-1:0]     w_prod;

    always_comb begin
        int idx;
        w_any      = 1'b0;
        w_grant_id = '0;
        idx        = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!w_any && req_valid_i[idx]) begin
                w_any      = 1'b1;
                w_grant_id = IdW'(idx);
            end
        end
    end

    assign w_adv   = ~r_vld[Latency] | rsp_ready_i[r_id[Latency]];
    // Held reset keeps the handshake closed so no pair is accepted and then discarded.
    assign w_issue = w_any & w_adv & rst_ni;

    always_comb begin
        req_ready_o             = '0;
        req_ready_o[w_grant_id] = w_issue;
    end

    assign w_x    = req_x_i[w_grant_id*widthX +: widthX];
    assign w_y    = req_y_i[w_grant_id*widthY +: widthY];
    assign w_prod = f_bw_mult(w_x, w_y);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
            r_ptr <= '0;
        end else begin
            if (w_adv) begin
                r_vld[1] <= w_issue;
                for (int s = 2; s <= Latency; s++) begin
                    r_vld[s] <= r_vld[s-1];
                end
            end
            if (w_issue) begin
                r_ptr <= (w_grant_id == IdW'(NumReq - 1)) ? '0 : w_grant_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_adv) begin
            r_id[1]   <= w_grant_id;
            r_prod[1] <= w_prod;
            for (int s = 2; s <= Latency; s++) begin
                r_id[s]   <= r_id[s-1];
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid_o                  = '0;
        rsp_valid_o[r_id[Latency]]   = r_vld[Latency];
    end

    assign rsp_p_o = r_prod[Latency];
    assign busy_o  = |r_vld;

endmodule
